// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Shares one UART transmitter between two byte requesters. Port 0 is the
// core's MMIO store path and port 1 is the debug/monitor path. Accepted bytes
// are queued in a small FIFO. They are issued as single-cycle write strobes.
// The transmitter has no busy output, so an internal guard timer spaces the
// strobes and no write lands while a frame is still shifting out.
//
// Optional feature, macro UART_TX_CRLF_EN: when the FIFO head is 0x0A, the
// block first sends 0x0D without popping. It then waits a full guard, and
// only after that pops and sends the 0x0A.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req0_valid   port 0 byte valid
//   req0_data    port 0 byte
//   req0_ready   port 0 byte accepted this cycle (combinational)
//   req1_valid   port 1 byte valid
//   req1_data    port 1 byte
//   req1_ready   port 1 byte accepted this cycle (combinational)
//   uart_we      one-cycle write strobe to the transmitter
//   uart_wr_data byte for the transmitter; holds its value between strobes
//   busy         FIFO non-empty or a frame still inside its guard window
//   fifo_count   current FIFO occupancy
module uart_tx_sched #(
    parameter int SYSCLK_FREQ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    input  logic [7:0]               req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [7:0]               req1_data,
    output logic                     req1_ready,
    output logic                     uart_we,
    output logic [7:0]               uart_wr_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    // Twelve bit-times per frame gives margin over the 10-bit frame. The +2
    // covers the pop cycle and the strobe cycle.
    localparam int GUARD_CYCLES = 12 * ((SYSCLK_FREQ + BAUD_RATE - 1) / BAUD_RATE) + 2;
    // WAIT spans GUARD_CYCLES-1 cycles (timer value down to 0). The following
    // IDLE cycle pops, so strobes land exactly GUARD_CYCLES apart.
    localparam logic [15:0] WAIT_LOAD = 16'(GUARD_CYCLES - 2);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);

`ifdef UART_TX_CRLF_EN
    localparam logic [7:0] LF_BYTE = 8'h0A;
    localparam logic [7:0] CR_BYTE = 8'h0D;
    // CR_WAIT pops on its final cycle instead of passing through IDLE, so it
    // runs one cycle longer to keep the same strobe spacing.
    localparam logic [15:0] CR_LOAD = 16'(GUARD_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, WAIT, CR_WAIT} state_t;
`else
    typedef enum logic [0:0] {IDLE, WAIT} state_t;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          last_srv;   // port served by the most recent transfer
    logic          grant0;
    logic          grant1;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic [7:0]    head;
    state_t        state;
    logic [15:0]   timer;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // On a tie, the port that was not served last wins.
    assign grant0 = req0_valid & (~req1_valid | last_srv);
    assign grant1 = req1_valid & (~req0_valid | ~last_srv);

    // full reflects the registered state, so a pop in this cycle does not
    // open a slot until the next cycle.
    assign req0_ready = grant0 & ~full;
    assign req1_ready = grant1 & ~full;
    assign push       = req0_ready | req1_ready;
    assign push_data  = req0_ready ? req0_data : req1_data;
    assign fifo_count = count;

    always_comb begin
        pop = 1'b0;
        case (state)
`ifdef UART_TX_CRLF_EN
            IDLE:    pop = ~empty & (head != LF_BYTE);
            CR_WAIT: pop = (timer == 16'd0);
`else
            IDLE:    pop = ~empty;
`endif
            default: pop = 1'b0;
        endcase
    end

    // FIFO storage. It has no reset because the pointers and count decide
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO control and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_srv <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                last_srv <= req1_ready;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issuer FSM. All of its outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            uart_we      <= 1'b0;
            uart_wr_data <= '0;
            busy         <= 1'b0;
        end else begin
            uart_we <= 1'b0;
            // Sampling the current state keeps busy high for one cycle after
            // WAIT ends. That is the cycle in which the guard has just expired.
            busy    <= push | ~empty | (state != IDLE);
            case (state)
                IDLE: begin
                    if (!empty) begin
                        uart_we <= 1'b1;
`ifdef UART_TX_CRLF_EN
                        if (head == LF_BYTE) begin
                            uart_wr_data <= CR_BYTE;
                            timer        <= CR_LOAD;
                            state        <= CR_WAIT;
                        end else begin
                            uart_wr_data <= head;
                            timer        <= WAIT_LOAD;
                            state        <= WAIT;
                        end
`else
                        uart_wr_data <= head;
                        timer        <= WAIT_LOAD;
                        state        <= WAIT;
`endif
                    end
                end
                WAIT: begin
                    if (timer == 16'd0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`ifdef UART_TX_CRLF_EN
                CR_WAIT: begin
                    if (timer == 16'd0) begin
                        uart_we      <= 1'b1;
                        uart_wr_data <= head;
                        timer        <= WAIT_LOAD;
                        state        <= WAIT;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched. It uses SYSCLK_FREQ=1000,
// BAUD_RATE=100 and DEPTH=4, which makes the guard 12*10+2 = 122 cycles.
// A transaction-level reference model runs alongside every test. Each
// accepted byte gets its issue time from
//   max(previous pulse + guard, accept + 2)
// and the model derives the expected readies, occupancy, busy and strobes
// from those times.
module tb_uart_tx_sched;

    localparam int SYS_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 4;
    localparam int G      = 122;

`ifdef UART_TX_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       uart_we;
    logic [7:0] uart_wr_data;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_sched #(
        .SYSCLK_FREQ (SYS_HZ),
        .BAUD_RATE   (BAUD),
        .DEPTH       (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .uart_we      (uart_we),
        .uart_wr_data (uart_wr_data),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Log of every strobe the DUT produces.
    typedef struct {
        int         t;
        logic [7:0] d;
    } pulse_t;
    pulse_t log_q[$];
    always @(negedge clk) begin
        if (rst_n && uart_we) log_q.push_back('{cyc, uart_wr_data});
    end

    // Reference model state.
    pulse_t m_pul[$];
    int     m_acc[$];
    int     m_pop[$];
    int     m_blo[$];
    int     m_bhi[$];
    bit     m_last;
    int     m_last_pulse;
    bit     acc0;
    bit     acc1;

    function automatic void model_reset();
        m_pul.delete();
        m_acc.delete();
        m_pop.delete();
        m_blo.delete();
        m_bhi.delete();
        m_last       = 1'b1;
        m_last_pulse = -100000;
    endfunction

    function automatic void model_accept(input logic [7:0] d, input bit port);
        int t0;
        t0 = (m_last_pulse + G > cyc + 2) ? m_last_pulse + G : cyc + 2;
        m_acc.push_back(cyc);
        if (CRLF && d == 8'h0A) begin
            m_pul.push_back('{t0, 8'h0D});
            m_pul.push_back('{t0 + G, 8'h0A});
            m_pop.push_back(t0 + G - 1);
            m_last_pulse = t0 + G;
        end else begin
            m_pul.push_back('{t0, d});
            m_pop.push_back(t0 - 1);
            m_last_pulse = t0;
        end
        m_blo.push_back(cyc + 1);
        m_bhi.push_back(m_last_pulse + G - 1);
        m_last = port;
    endfunction

    always @(negedge clk) begin : monitor
        int         cnt;
        int         best;
        bit         ewe;
        bit         ebsy;
        bit         full;
        bit         g0;
        bit         g1;
        bit         r0;
        bit         r1;
        logic [7:0] ed;
        if (!rst_n) begin
            model_reset();
            acc0 = 1'b0;
            acc1 = 1'b0;
        end else begin
            cnt = 0;
            foreach (m_acc[i]) if (m_acc[i] < cyc) cnt++;
            foreach (m_pop[i]) if (m_pop[i] < cyc) cnt--;
            ewe  = 1'b0;
            ed   = 8'h00;
            best = -1;
            foreach (m_pul[i]) begin
                if (m_pul[i].t == cyc) ewe = 1'b1;
                if (m_pul[i].t <= cyc && m_pul[i].t > best) begin
                    best = m_pul[i].t;
                    ed   = m_pul[i].d;
                end
            end
            ebsy = 1'b0;
            foreach (m_blo[i]) if (cyc >= m_blo[i] && cyc <= m_bhi[i]) ebsy = 1'b1;
            full = (cnt >= DEPTH);
            g0   = req0_valid && (!req1_valid || m_last);
            g1   = req1_valid && (!req0_valid || !m_last);
            r0   = g0 && !full;
            r1   = g1 && !full;
            check("mdl_req0_ready", req0_ready, r0);
            check("mdl_req1_ready", req1_ready, r1);
            check("mdl_uart_we", uart_we, ewe);
            check("mdl_uart_wr_data", uart_wr_data, ed);
            check("mdl_busy", busy, ebsy);
            check("mdl_fifo_count", fifo_count, cnt);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (r0) model_accept(req0_data, 1'b0);
            else if (r1) model_accept(req1_data, 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Present one byte and hold it until accepted; t is the handshake cycle.
    task automatic send(input bit port, input logic [7:0] d, output int t);
        t = -1;
        if (port) begin req1_valid = 1'b1; req1_data = d; end
        else      begin req0_valid = 1'b1; req0_data = d; end
        for (int k = 0; k < 1000 && t < 0; k++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) t = cyc;
            tick();
        end
        if (port) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
        check("send_accepted", (t >= 0), 1);
    endtask

    // Wait for busy to fall; tf is the first cycle with busy low.
    task automatic drain(output int tf);
        tf = -1;
        for (int k = 0; k < 3000; k++) begin
            if (busy === 1'b0) begin
                tf = cyc;
                break;
            end
            tick();
        end
        check("drain_done", (tf >= 0), 1);
    endtask

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(0, 7) == 0) return 8'h0A;
        return 8'($urandom_range(0, 255));
    endfunction

    typedef struct {
        bit         v0;
        logic [7:0] d0;
        bit         v1;
        logic [7:0] d1;
        bit         r0;
        bit         r1;
        int         cnt;
    } vec_t;

    initial begin
        vec_t       tbl[7];
        logic [7:0] tbl_exp[5];
        int         t;
        int         tf;
        int         i;
        int         stall;

        tbl[0] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 8'h11, 1'b1, 8'h20, 1'b0, 1'b1, 1};
        tbl[2] = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b1, 1'b0, 1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 1'b1, 2};
        tbl[4] = '{1'b1, 8'h12, 1'b1, 8'h22, 1'b1, 1'b0, 3};
        tbl[5] = '{1'b1, 8'h13, 1'b1, 8'h22, 1'b0, 1'b0, 4};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4};
        tbl_exp = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12};

        // Reset values
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_uart_we", uart_we, 0);
        check("rst_uart_wr_data", uart_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        rst_n = 1'b1;
        tick();

        // Arbitration / full table
        do_reset();
        log_q.delete();
        for (int r = 0; r < 7; r++) begin
            req0_valid = tbl[r].v0;
            req0_data  = tbl[r].d0;
            req1_valid = tbl[r].v1;
            req1_data  = tbl[r].d1;
            @(negedge clk);
            check($sformatf("tbl%0d_req0_ready", r), req0_ready, tbl[r].r0);
            check($sformatf("tbl%0d_req1_ready", r), req1_ready, tbl[r].r1);
            check($sformatf("tbl%0d_fifo_count", r), fifo_count, tbl[r].cnt);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain(tf);
        check("tbl_pulses", log_q.size(), 5);
        for (int k = 0; k < 5; k++) check($sformatf("tbl_data%0d", k), log_q[k].d, tbl_exp[k]);
        for (int k = 1; k < 5; k++) check($sformatf("tbl_gap%0d", k), log_q[k].t - log_q[k-1].t, G);

        // Single byte
        do_reset();
        log_q.delete();
        send(1'b0, 8'h41, t);
        check("t1_busy_rise", busy, 1);
        drain(tf);
        check("t1_pulses", log_q.size(), 1);
        check("t1_latency", log_q[0].t - t, 2);
        check("t1_data", log_q[0].d, 8'h41);
        check("t1_busy_fall", tf - log_q[0].t, G);

        // Tie
        do_reset();
        log_q.delete();
        req0_valid = 1'b1; req0_data = 8'h30;
        req1_valid = 1'b1; req1_data = 8'h31;
        @(negedge clk);
        check("t2_tie_req0_ready", req0_ready, 1);
        check("t2_tie_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t2_next_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        drain(tf);
        check("t2_pulses", log_q.size(), 2);
        check("t2_data0", log_q[0].d, 8'h30);
        check("t2_data1", log_q[1].d, 8'h31);
        check("t2_gap", log_q[1].t - log_q[0].t, G);

        // Full FIFO
        do_reset();
        log_q.delete();
        i = 0;
        stall = 0;
        req0_valid = 1'b1;
        req0_data  = 8'h01;
        for (int k = 0; k < 1000 && i < 6; k++) begin
            @(negedge clk);
            if (req0_ready) begin
                if (stall == 1) begin
                    check("t3_reassert_count", fifo_count, 3);
                    stall = 2;
                end
                i++;
            end else if (stall == 0) begin
                check("t3_full_count", fifo_count, 4);
                check("t3_stall_index", i, 5);
                stall = 1;
            end
            tick();
            req0_data = 8'(i + 1);
            if (i == 6) req0_valid = 1'b0;
        end
        req0_valid = 1'b0;
        check("t3_stall_seen", stall, 2);
        drain(tf);
        check("t3_pulses", log_q.size(), 6);
        for (int k = 0; k < 6; k++) check($sformatf("t3_data%0d", k), log_q[k].d, 8'(k + 1));
        for (int k = 1; k < 6; k++) check($sformatf("t3_gap%0d", k), log_q[k].t - log_q[k-1].t, G);

        // Reset mid-operation
        do_reset();
        log_q.delete();
        send(1'b0, 8'hA1, t);
        send(1'b0, 8'hA2, t);
        send(1'b0, 8'hA3, t);
        repeat (3) tick();
        @(negedge clk);
        check("t4_queued", fifo_count, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_uart_we", uart_we, 0);
        check("t4_rst_fifo_count", fifo_count, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_uart_wr_data", uart_wr_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        log_q.delete();
        send(1'b0, 8'h55, t);
        drain(tf);
        check("t4_pulses", log_q.size(), 1);
        check("t4_latency", log_q[0].t - t, 2);
        check("t4_data", log_q[0].d, 8'h55);

        // Line feed
        do_reset();
        log_q.delete();
        send(1'b1, 8'h0A, t);
        drain(tf);
`ifdef UART_TX_CRLF_EN
        check("t5_pulses", log_q.size(), 2);
        check("t5_latency", log_q[0].t - t, 2);
        check("t5_cr", log_q[0].d, 8'h0D);
        check("t5_lf", log_q[1].d, 8'h0A);
        check("t5_gap", log_q[1].t - log_q[0].t, G);
`else
        check("t5_pulses", log_q.size(), 1);
        check("t5_latency", log_q[0].t - t, 2);
        check("t5_lf", log_q[0].d, 8'h0A);
`endif

        // Random traffic against the model
        do_reset();
        log_q.delete();
        for (int k = 0; k < 4000; k++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 99) < 3);
                req0_data  = rnd_byte();
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 99) < 3);
                req1_data  = rnd_byte();
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain(tf);
        check("rand_pulse_count", log_q.size(), m_pul.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
